// File: rtl/simon_pkg.sv
// Shared types and sizing for the Simon Says sequence player and its helpers.
package simon_pkg;

  localparam int DATA_W    = 6;
  localparam int ADDR_W    = 5;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int TIMER_W   = 8;

  typedef logic [DATA_W-1:0] symbol_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_P_RD,
    ST_P_WAIT,
    ST_P_SHOW,
    ST_P_GAP,
    ST_C_PRESS,
    ST_C_RD,
    ST_C_WAIT,
    ST_PASS,
    ST_FAIL
  } player_state_e;

endpackage

// File: rtl/simon_seq_player_hold_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero, so a
// load of N-1 gives a window of exactly N cycles.
module hold_timer #(
  parameter int CNT_W = simon_pkg::TIMER_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/simon_seq_player.sv
// Simon Says round controller: reads the stored pattern, shows it symbol by
// symbol, then checks the player's presses against a second read of each entry.
module simon_seq_player #(
  parameter int DATA_W      = simon_pkg::DATA_W,
  parameter int ADDR_W      = simon_pkg::ADDR_W,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] r_ptr,
  output logic              r_en,
  input  logic [DATA_W-1:0] data_Out,
  output logic              show_valid,
  output logic [DATA_W-1:0] show_data,
  output logic              press_ready,
  input  logic              press_valid,
  input  logic [DATA_W-1:0] press_data,
  output logic              busy,
  output logic              pass,
  output logic              fail
);

  import simon_pkg::*;

  localparam logic [TIMER_W-1:0] HOLD_LD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0]    LEN_MAX = (ADDR_W+1)'(1 << ADDR_W);

  player_state_e      state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [DATA_W-1:0]  show_q, show_d;
  logic [DATA_W-1:0]  press_q, press_d;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_done;
  logic               last_idx;
  logic               start_ok;

  assign last_idx = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));
  assign start_ok = start && (seq_len != '0) && (seq_len <= LEN_MAX);

  hold_timer #(.CNT_W(TIMER_W)) u_hold_timer (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  // Symbol and press holding registers carry no reset; show_data is gated
  // by show_valid and press_q is only read after being written.
  always_ff @(posedge clk) begin
    show_q  <= show_d;
    press_q <= press_d;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    show_d    = show_q;
    press_d   = press_q;
    tmr_load  = 1'b0;
    tmr_value = HOLD_LD;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          len_d   = seq_len;
          idx_d   = '0;
          state_d = ST_P_RD;
        end
      end
      ST_P_RD:   state_d = ST_P_WAIT;
      ST_P_WAIT: begin
        show_d    = data_Out;
        tmr_load  = 1'b1;
        tmr_value = HOLD_LD;
        state_d   = ST_P_SHOW;
      end
      ST_P_SHOW: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = GAP_LD;
          state_d   = ST_P_GAP;
        end
      end
      ST_P_GAP: begin
        if (tmr_done) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_C_PRESS;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_P_RD;
          end
        end
      end
      ST_C_PRESS: begin
        if (press_valid) begin
          press_d = press_data;
          state_d = ST_C_RD;
        end
      end
      ST_C_RD:   state_d = ST_C_WAIT;
      ST_C_WAIT: begin
        if (data_Out != press_q) begin
          state_d = ST_FAIL;
        end else if (last_idx) begin
          state_d = ST_PASS;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_C_PRESS;
        end
      end
      ST_PASS:  state_d = ST_IDLE;
      ST_FAIL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    r_en        = (state_q == ST_P_RD) || (state_q == ST_C_RD);
    r_ptr       = r_en ? idx_q : '0;
    show_valid  = (state_q == ST_P_SHOW);
    show_data   = show_valid ? show_q : '0;
    press_ready = (state_q == ST_C_PRESS);
    busy        = (state_q != ST_IDLE);
    pass        = (state_q == ST_PASS);
    fail        = (state_q == ST_FAIL);
  end

endmodule

// File: tb/tb_simon_seq_player.sv
// Directed bench for simon_seq_player with a 1-cycle registered-read memory.
module tb_simon_seq_player;

  logic       clk = 1'b0;
  logic       reset, start, press_valid;
  logic [5:0] seq_len;
  logic [5:0] data_Out, press_data, show_data;
  logic [4:0] r_ptr;
  logic       r_en, show_valid, press_ready, busy, pass, fail;
  logic [5:0] mem [32];
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int fail_cnt = 0;

  simon_seq_player dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seq_len     (seq_len),
    .r_ptr       (r_ptr),
    .r_en        (r_en),
    .data_Out    (data_Out),
    .show_valid  (show_valid),
    .show_data   (show_data),
    .press_ready (press_ready),
    .press_valid (press_valid),
    .press_data  (press_data),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (r_en) data_Out <= mem[r_ptr];

  always @(negedge clk) begin
    if (r_en) rd_cnt++;
    if (fail) fail_cnt++;
  end

  assign obs = {r_en, r_ptr, show_valid, show_data, press_ready, pass, fail, busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs at play-phase cycle c (c=0 is P_RD of symbol 0).
  function automatic logic [16:0] exp_play(int c, bit rev);
    int k, p;
    logic re, sv;
    logic [4:0] ptr;
    logic [5:0] sd;
    k   = c / 8;
    p   = c % 8;
    re  = (p == 0);
    ptr = re ? 5'(k) : 5'd0;
    sv  = (p >= 2) && (p <= 5);
    sd  = sv ? (rev ? 6'(31 - k) : 6'(k)) : 6'd0;
    return {re, ptr, sv, sd, 1'b0, 1'b0, 1'b0, 1'b1};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; press_valid = 1'b0; press_data = '0; seq_len = '0;
    tick(); tick();
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 17'd0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected %h", obs, 17'd0);
    end
  endtask

  task automatic test_full_match();
    int f0;
    f0 = fail_cnt;
    seq_len = 6'd8; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 64; c++) begin
      checks++;
      if (obs !== exp_play(c, 1'b0)) begin
        errors++; $display("FAIL match_play c=%0d: got %h expected %h", c, obs, exp_play(c, 1'b0));
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (press_ready !== 1'b1) begin
        errors++; $display("FAIL match_ready i=%0d: got %b expected 1", i, press_ready);
      end
      press_valid = 1'b1; press_data = 6'(i); tick(); press_valid = 1'b0;
      checks++;
      if ({r_en, r_ptr, press_ready} !== {1'b1, 5'(i), 1'b0}) begin
        errors++; $display("FAIL match_crd i=%0d: got %b expected %b", i, {r_en, r_ptr, press_ready}, {1'b1, 5'(i), 1'b0});
      end
      tick(); tick();
      checks++;
      if ({pass, fail, press_ready} !== {1'(i == 7), 1'b0, 1'(i < 7)}) begin
        errors++; $display("FAIL match_result i=%0d: got %b expected %b", i, {pass, fail, press_ready}, {1'(i == 7), 1'b0, 1'(i < 7)});
      end
    end
    tick();
    checks++;
    if ({busy, pass, fail_cnt - f0} !== {1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL match_end: got busy=%b pass=%b fails=%0d expected 0 0 0", busy, pass, fail_cnt - f0);
    end
  endtask

  task automatic test_mismatch();
    int r0, f0;
    logic [5:0] presses [3];
    presses = '{6'd0, 6'd1, 6'd5};
    r0 = rd_cnt; f0 = fail_cnt;
    seq_len = 6'd4; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (obs !== exp_play(c, 1'b0)) begin
        errors++; $display("FAIL mis_play c=%0d: got %h expected %h", c, obs, exp_play(c, 1'b0));
      end
      tick();
    end
    checks++;
    if (rd_cnt - r0 !== 4) begin
      errors++; $display("FAIL mis_play_reads: got %0d expected 4", rd_cnt - r0);
    end
    r0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      press_valid = 1'b1; press_data = presses[i]; tick(); press_valid = 1'b0;
      tick(); tick();
      checks++;
      if ({pass, fail, press_ready} !== {1'b0, 1'(i == 2), 1'(i < 2)}) begin
        errors++; $display("FAIL mis_result i=%0d: got %b expected %b", i, {pass, fail, press_ready}, {1'b0, 1'(i == 2), 1'(i < 2)});
      end
    end
    tick();
    checks++;
    if ({busy, fail} !== 2'b00) begin
      errors++; $display("FAIL mis_idle: got %b expected 00", {busy, fail});
    end
    checks++;
    if ((rd_cnt - r0 !== 3) || (fail_cnt - f0 !== 1)) begin
      errors++; $display("FAIL mis_counts: got reads=%0d fails=%0d expected 3 1", rd_cnt - r0, fail_cnt - f0);
    end
  endtask

  task automatic test_single_and_invalid();
    int bad_lens [2];
    bad_lens = '{0, 33};
    seq_len = 6'd1; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs !== exp_play(c, 1'b0)) begin
        errors++; $display("FAIL single_play c=%0d: got %h expected %h", c, obs, exp_play(c, 1'b0));
      end
      tick();
    end
    press_valid = 1'b1; press_data = 6'd0; tick(); press_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({pass, fail} !== 2'b10) begin
      errors++; $display("FAIL single_pass: got %b expected 10", {pass, fail});
    end
    tick();
    for (int b = 0; b < 2; b++) begin
      seq_len = 6'(bad_lens[b]); start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({busy, r_en} !== 2'b00) begin
          errors++; $display("FAIL bad_len len=%0d c=%0d: got %b expected 00", bad_lens[b], c, {busy, r_en});
        end
        tick();
      end
    end
  endtask

  task automatic test_dropped_inputs();
    seq_len = 6'd2; start = 1'b1; tick(); start = 1'b0;
    press_valid = 1'b1; press_data = 6'd0;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (obs !== exp_play(c, 1'b0)) begin
        errors++; $display("FAIL drop_play c=%0d: got %h expected %h", c, obs, exp_play(c, 1'b0));
      end
      // a start with a different length lands in the middle of the play phase
      start = (c == 4); seq_len = (c == 4) ? 6'd1 : 6'd2;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      press_valid = 1'b1; press_data = 6'(i); tick(); press_valid = 1'b0;
      checks++;
      if ({r_en, r_ptr} !== {1'b1, 5'(i)}) begin
        errors++; $display("FAIL drop_crd i=%0d: got %b expected %b", i, {r_en, r_ptr}, {1'b1, 5'(i)});
      end
      tick(); tick();
      checks++;
      if ({pass, fail, press_ready} !== {1'(i == 1), 1'b0, 1'(i == 0)}) begin
        errors++; $display("FAIL drop_result i=%0d: got %b expected %b", i, {pass, fail, press_ready}, {1'(i == 1), 1'b0, 1'(i == 0)});
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_round();
    seq_len = 6'd8; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 27; c++) begin
      checks++;
      if (obs !== exp_play(c, 1'b0)) begin
        errors++; $display("FAIL rst_pre c=%0d: got %h expected %h", c, obs, exp_play(c, 1'b0));
      end
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h expected %h", obs, 17'd0);
    end
    seq_len = 6'd2; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (obs !== exp_play(c, 1'b0)) begin
        errors++; $display("FAIL rst_replay c=%0d: got %h expected %h", c, obs, exp_play(c, 1'b0));
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      press_valid = 1'b1; press_data = 6'(i); tick(); press_valid = 1'b0;
      tick(); tick();
    end
    checks++;
    if ({pass, fail} !== 2'b10) begin
      errors++; $display("FAIL rst_replay_pass: got %b expected 10", {pass, fail});
    end
    tick();
  endtask

  task automatic test_full_depth();
    for (int k = 0; k < 32; k++) mem[k] = 6'(31 - k);
    seq_len = 6'd32; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 256; c++) begin
      checks++;
      if (obs !== exp_play(c, 1'b1)) begin
        errors++; $display("FAIL depth_play c=%0d: got %h expected %h", c, obs, exp_play(c, 1'b1));
      end
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      press_valid = 1'b1; press_data = 6'(31 - i); tick(); press_valid = 1'b0;
      checks++;
      if ({r_en, r_ptr} !== {1'b1, 5'(i)}) begin
        errors++; $display("FAIL depth_crd i=%0d: got %b expected %b", i, {r_en, r_ptr}, {1'b1, 5'(i)});
      end
      tick(); tick();
      checks++;
      if ({pass, fail, press_ready} !== {1'(i == 31), 1'b0, 1'(i < 31)}) begin
        errors++; $display("FAIL depth_result i=%0d: got %b expected %b", i, {pass, fail, press_ready}, {1'(i == 31), 1'b0, 1'(i < 31)});
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL depth_idle: got %b expected 0", busy);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = (k < 8) ? 6'(k) : 6'd0;
    test_reset();
    test_full_match();
    test_mismatch();
    test_single_and_invalid();
    test_dropped_inputs();
    test_reset_mid_round();
    test_full_depth();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
